// File: rtl/cpu_core.sv
// cpu_core: multi-cycle, non-pipelined 32-bit MIPS-subset core.
// One unified memory on a shared tri-state data bus; PC/IR/A/ALUOut exported for debug.
module cpu_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [31:0] BUS,
  output logic        Memread,
  output logic        Memwrite,
  output logic [31:0] Addr,
  output logic [31:0] A,
  output logic [31:0] PC,
  output logic [31:0] IR,
  output logic [31:0] Alures
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;

  // FETCH must encode as zero so power-up state is FETCH
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_NOR = 6'h27;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   ir_q, ir_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   alu_q, alu_d;
  logic [XLEN-1:0]   mdr_q, mdr_d;
  logic [XLEN-1:0]   rf_q [NREGS];

  logic              rf_we;
  logic [4:0]        rf_wa;
  logic [XLEN-1:0]   rf_wd;

  logic [5:0]        op, funct;
  logic [4:0]        rs, rt, rd;
  logic [XLEN-1:0]   sext_imm, zext_imm, alu_res;
  logic              is_ralu, is_ialu, is_lw, is_sw, is_beq, is_bne, is_j;

  assign op       = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign sext_imm = {{16{ir_q[15]}}, ir_q[15:0]};
  assign zext_imm = {16'h0000, ir_q[15:0]};

  // Instruction class decode from the latched IR
  always_comb begin
    is_ralu = (op == OP_RTYPE) &&
              ((funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
               (funct == FN_OR)  || (funct == FN_SLT) || (funct == FN_NOR));
    is_ialu = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) ||
              (op == OP_SLTI) || (op == OP_LUI);
    is_lw   = (op == OP_LW);
    is_sw   = (op == OP_SW);
    is_beq  = (op == OP_BEQ);
    is_bne  = (op == OP_BNE);
    is_j    = (op == OP_J);
  end

  // ALU result for R-type and immediate ALU ops
  always_comb begin
    alu_res = '0;
    if (is_ralu) begin
      case (funct)
        FN_ADD:  alu_res = a_q + b_q;
        FN_SUB:  alu_res = a_q - b_q;
        FN_AND:  alu_res = a_q & b_q;
        FN_OR:   alu_res = a_q | b_q;
        FN_SLT:  alu_res = {31'd0, ($signed(a_q) < $signed(b_q))};
        FN_NOR:  alu_res = ~(a_q | b_q);
        default: alu_res = '0;
      endcase
    end else begin
      case (op)
        OP_ADDI: alu_res = a_q + sext_imm;
        OP_ANDI: alu_res = a_q & zext_imm;
        OP_ORI:  alu_res = a_q | zext_imm;
        OP_SLTI: alu_res = {31'd0, ($signed(a_q) < $signed(sext_imm))};
        OP_LUI:  alu_res = {ir_q[15:0], 16'h0000};
        default: alu_res = '0;
      endcase
    end
  end

  // Next-state and datapath register updates per FSM state
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    alu_d   = alu_q;
    mdr_d   = mdr_q;
    rf_we   = 1'b0;
    rf_wa   = 5'd0;
    rf_wd   = '0;
    case (state_q)
      S_FETCH: begin
        ir_d    = BUS;
        pc_d    = pc_q + 32'd4;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d   = rf_q[rs];
        b_d   = rf_q[rt];
        alu_d = pc_q + {sext_imm[29:0], 2'b00};
        if (is_j) begin
          pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
          state_d = S_FETCH;
        end else if (is_ralu || is_ialu || is_lw || is_sw || is_beq || is_bne) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        if (is_lw || is_sw) begin
          alu_d   = a_q + sext_imm;
          state_d = S_MEM;
        end else if (is_beq || is_bne) begin
          if ((is_beq && (a_q == b_q)) || (is_bne && (a_q != b_q))) pc_d = alu_q;
          state_d = S_FETCH;
        end else begin
          alu_d   = alu_res;
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (is_lw) begin
          mdr_d   = BUS;
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        rf_wa   = is_ralu ? rd : rt;
        rf_wd   = is_lw ? mdr_q : alu_q;
        rf_we   = (rf_wa != 5'd0);
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // State, datapath and register-file flops; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      if (rf_we) rf_q[rf_wa] <= rf_wd;
    end
  end

  // Memory strobes follow the state and are held low while in reset
  assign Memread  = !rst && ((state_q == S_FETCH) || ((state_q == S_MEM) && is_lw));
  assign Memwrite = !rst && (state_q == S_MEM) && is_sw;
  assign Addr     = (state_q == S_FETCH) ? pc_q : alu_q;
  assign BUS      = Memwrite ? b_q : {XLEN{1'bz}};

  assign A      = a_q;
  assign PC     = pc_q;
  assign IR     = ir_q;
  assign Alures = alu_q;

endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: scoreboard bench for cpu_core; expected bus events are queued per program.
module tb_cpu_core;

  typedef struct {
    int          cyc;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  localparam logic [31:0] SENT = 32'hDEAD_BEEF;

  logic        clk = 1'b1;
  logic        rst = 1'b0;
  wire  [31:0] BUS;
  logic        Memread, Memwrite;
  logic [31:0] Addr, A, PC, IR, Alures;

  logic [31:0] prog [16];
  logic [31:0] ram  [256];
  logic [31:0] rd_data;

  int  errors = 0;
  int  checks = 0;
  int  cyc    = -1;
  ev_t exp_q [$];

  always #5 clk = ~clk;

  cpu_core dut (
    .clk      (clk),
    .rst      (rst),
    .BUS      (BUS),
    .Memread  (Memread),
    .Memwrite (Memwrite),
    .Addr     (Addr),
    .A        (A),
    .PC       (PC),
    .IR       (IR),
    .Alures   (Alures)
  );

  // Memory model: program ROM below 0x40, RAM above; idle cycles show a sentinel
  assign rd_data = (Addr < 32'h40) ? prog[Addr[5:2]] : ram[Addr[9:2]];
  assign BUS     = Memwrite ? 32'bz : (Memread ? rd_data : SENT);

  always @(posedge clk) if (Memwrite) ram[Addr[9:2]] <= BUS;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_ev(input int c, input bit wr, input logic [31:0] addr, input logic [31:0] data);
    ev_t e;
    e.cyc = c; e.wr = wr; e.addr = addr; e.data = data;
    exp_q.push_back(e);
  endtask

  // Advance one cycle, sample at the falling edge and drain the scoreboard
  task automatic sb_tick();
    ev_t e;
    @(negedge clk);
    cyc++;
    checks++;
    if (Memread || Memwrite) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL bus_unexpected: cyc=%0d rd=%b wr=%b addr=%h bus=%h, required no access",
                 cyc, Memread, Memwrite, Addr, BUS);
      end else begin
        e = exp_q.pop_front();
        if (cyc !== e.cyc || Memwrite !== e.wr || Memread !== !e.wr || Addr !== e.addr ||
            (e.wr && BUS !== e.data)) begin
          errors++;
          $display("FAIL bus_event: got cyc=%0d rd=%b wr=%b addr=%h bus=%h, required cyc=%0d wr=%b addr=%h data=%h",
                   cyc, Memread, Memwrite, Addr, BUS, e.cyc, e.wr, e.addr, e.data);
        end
      end
    end else if (BUS !== SENT) begin
      errors++;
      $display("FAIL bus_idle: cyc=%0d bus=%h, required undriven by cpu (%h)", cyc, BUS, SENT);
    end
  endtask

  task automatic run_to(input int k);
    while (cyc < k) sb_tick();
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1 rst = 1'b0;
    cyc = -1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = 32'h0;
  endtask

  task automatic test_no_reset();
    clear_prog();
    prog[0] = 32'h202100E9;
    prog[1] = 32'h202100E9;
    prog[2] = 32'hAC01007B;
    prog[3] = 32'h08000000;
    push_ev(0,  1'b0, 32'h00, 32'h0);
    push_ev(4,  1'b0, 32'h04, 32'h0);
    push_ev(8,  1'b0, 32'h08, 32'h0);
    push_ev(11, 1'b1, 32'h7B, 32'h1D2);
    push_ev(12, 1'b0, 32'h0C, 32'h0);
    push_ev(14, 1'b0, 32'h00, 32'h0);
    run_to(3);
    checks++;
    if (PC !== 32'h4 || IR !== 32'h202100E9) begin
      errors++;
      $display("FAIL first_fetch: PC=%h IR=%h, required PC=00000004 IR=202100e9", PC, IR);
    end
    checks++;
    if (Alures !== 32'hE9) begin
      errors++;
      $display("FAIL addi1_alures: got %h, required 000000e9", Alures);
    end
    run_to(7);
    checks++;
    if (Alures !== 32'h1D2 || PC !== 32'h8) begin
      errors++;
      $display("FAIL addi2_alures: Alures=%h PC=%h, required 000001d2 00000008", Alures, PC);
    end
    run_to(14);
    checks++;
    if (PC !== 32'h0 || Addr !== 32'h0) begin
      errors++;
      $display("FAIL jump_zero: PC=%h Addr=%h, required 0 0", PC, Addr);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL no_reset_missing: %0d events left, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (PC !== 32'h0 || IR !== 32'h0 || A !== 32'h0 || Alures !== 32'h0 || Addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs: PC=%h IR=%h A=%h Alures=%h Addr=%h, required all 0", PC, IR, A, Alures, Addr);
    end
    @(posedge clk);
    #1;
    checks++;
    if (Memread !== 1'b0 || Memwrite !== 1'b0 || BUS !== SENT) begin
      errors++;
      $display("FAIL reset_strobes: rd=%b wr=%b bus=%h, required 0 0 %h", Memread, Memwrite, BUS, SENT);
    end
  endtask

  task automatic test_lw_sw_add();
    rst = 1'b1;
    clear_prog();
    prog[0] = 32'h3C021234;
    prog[1] = 32'h34425678;
    prog[2] = 32'hAC020100;
    prog[3] = 32'h8C030100;
    prog[4] = 32'h00632020;
    prog[5] = 32'h08000005;
    push_ev(0,  1'b0, 32'h000, 32'h0);
    push_ev(4,  1'b0, 32'h004, 32'h0);
    push_ev(8,  1'b0, 32'h008, 32'h0);
    push_ev(11, 1'b1, 32'h100, 32'h12345678);
    push_ev(12, 1'b0, 32'h00C, 32'h0);
    push_ev(15, 1'b0, 32'h100, 32'h0);
    push_ev(17, 1'b0, 32'h010, 32'h0);
    push_ev(21, 1'b0, 32'h014, 32'h0);
    release_rst();
    run_to(20);
    checks++;
    if (Alures !== 32'h2468ACF0) begin
      errors++;
      $display("FAIL add_result: got %h, required 2468acf0", Alures);
    end
    checks++;
    if (A !== 32'h12345678) begin
      errors++;
      $display("FAIL lw_a_operand: got %h, required 12345678", A);
    end
    run_to(21);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL lw_sw_missing: %0d events left, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_branch();
    rst = 1'b1;
    clear_prog();
    prog[0] = 32'h14000005;
    prog[1] = 32'h1000FFFF;
    push_ev(0, 1'b0, 32'h0, 32'h0);
    push_ev(3, 1'b0, 32'h4, 32'h0);
    push_ev(6, 1'b0, 32'h4, 32'h0);
    push_ev(9, 1'b0, 32'h4, 32'h0);
    release_rst();
    run_to(5);
    checks++;
    if (PC !== 32'h8) begin
      errors++;
      $display("FAIL beq_exec_pc: got %h, required 00000008", PC);
    end
    run_to(9);
    checks++;
    if (PC !== 32'h4) begin
      errors++;
      $display("FAIL beq_loop_pc: got %h, required 00000004", PC);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL branch_missing: %0d events left, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_exec();
    rst = 1'b1;
    clear_prog();
    prog[0] = 32'h20010007;
    prog[1] = 32'h20210001;
    push_ev(0, 1'b0, 32'h0, 32'h0);
    push_ev(4, 1'b0, 32'h4, 32'h0);
    release_rst();
    run_to(6);
    checks++;
    if (A !== 32'h7 || PC !== 32'h8) begin
      errors++;
      $display("FAIL pre_abort_state: A=%h PC=%h, required 00000007 00000008", A, PC);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (PC !== 32'h0 || IR !== 32'h0 || A !== 32'h0 || Alures !== 32'h0 ||
        Memread !== 1'b0 || Memwrite !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs: PC=%h IR=%h A=%h Alures=%h rd=%b wr=%b, required all 0",
               PC, IR, A, Alures, Memread, Memwrite);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_missing: %0d events left, required 0", exp_q.size());
    end
    exp_q.delete();
    clear_prog();
    prog[0] = 32'h20000005;
    prog[1] = 32'hAC000080;
    prog[2] = 32'h08000002;
    push_ev(0,  1'b0, 32'h00, 32'h0);
    push_ev(4,  1'b0, 32'h04, 32'h0);
    push_ev(7,  1'b1, 32'h80, 32'h0);
    push_ev(8,  1'b0, 32'h08, 32'h0);
    push_ev(10, 1'b0, 32'h08, 32'h0);
    @(posedge clk);
    release_rst();
    run_to(10);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL zero_reg_missing: %0d events left, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  initial begin
    test_no_reset();
    test_reset();
    test_lw_sw_add();
    test_branch();
    test_reset_mid_exec();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
